// File: rtl/serial_add_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding, slice width and
// the per-width nibble count.
package serial_add_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int unsigned nibble_count(input int unsigned width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/serial_nibble_adder_fa4bit.sv
// FA4bit: 4-bit ripple-carry adder slice, the single reused datapath element
// of serial_nibble_adder.
module FA4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int unsigned i = 0; i < 4; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[4];
  end

endmodule

// File: rtl/serial_nibble_adder.sv
// Nibble-serial adder: {c_out,sum} = a + b + c_in over WIDTH/4 cycles, LSB first.
// Define SERIAL_ADD_SUB_EN to add the 'sub' port (a - b via ~b and carry-in 1).
module serial_nibble_adder
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned N  = nibble_count(WIDTH);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [NIB_W-1:0] w_nib_a;
  logic [NIB_W-1:0] w_nib_b;
  logic [NIB_W-1:0] w_nib_s;
  logic             w_nib_c;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1; the operand is inverted once at acceptance.
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : c_in;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = c_in;
`endif

  assign w_nib_a = r_a[{r_cnt, 2'b00} +: NIB_W];
  assign w_nib_b = r_b[{r_cnt, 2'b00} +: NIB_W];

  FA4bit u_slice (
    .i_a    (w_nib_a),
    .i_b    (w_nib_b),
    .i_cin  (r_carry),
    .o_sum  (w_nib_s),
    .o_cout (w_nib_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[{r_cnt, 2'b00} +: NIB_W] <= w_nib_s;
          r_carry                        <= w_nib_c;
          // Counter only wraps on the RUN->DONE edge.
          if (r_cnt == LAST) begin
            r_cout  <= w_nib_c;
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Self-checking bench for serial_nibble_adder (WIDTH=64) against an arithmetic
// reference; subtract cases run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_nibble_adder;

  localparam int unsigned W = 64;
  localparam int unsigned N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_nibble_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    return r;
  endfunction

  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x - y;
    return {(x >= y), d};
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Presents operands and start before an edge; returns #1 after that (accepting) edge.
  task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    c_in  = tc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== '0)     begin failures++; $display("FAIL reset_sum got=%h exp=0", sum); end
    checks++; if (c_out !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", c_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W:0] exp;
    exp = ref_add(64'h1, 64'h2, 1'b0);
    drive_start(64'h1, 64'h2, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_k got=%b exp=1", busy); end
    for (int i = 1; i <= int'(N); i++) begin
      @(posedge clk);
      #1;
      if (i < int'(N)) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          failures++; $display("FAIL basic_run cyc=%0d busy=%b done=%b exp busy=1 done=0", i, busy, done);
        end
      end else begin
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
        checks++;
        if ({c_out, sum} !== exp) begin
          failures++; $display("FAIL basic_result got=%b_%h exp=%b_%h", c_out, sum, exp[W], exp[W-1:0]);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || {c_out, sum} !== exp) begin
        failures++; $display("FAIL basic_hold cyc=%0d done=%b got=%b_%h exp done=0 %b_%h", i, done, c_out, sum, exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_carry_ripple();
    int cyc;
    logic [W:0] exp;
    exp = ref_add('1, '0, 1'b1);
    drive_start('1, '0, 1'b1);
    wait_done(N + 4, cyc);
    checks++; if (cyc != int'(N)) begin failures++; $display("FAIL ripple_latency got=%0d exp=%0d", cyc, N); end
    checks++;
    if ({c_out, sum} !== exp) begin
      failures++; $display("FAIL ripple_result got=%b_%h exp=%b_%h", c_out, sum, exp[W], exp[W-1:0]);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    int cyc;
    logic [W-1:0] x, y;
    logic ci;
    logic [W:0] exp;
    for (int t = 0; t < 10; t++) begin
      x  = rnd64();
      y  = (t == 0) ? ~x : rnd64();
      ci = 1'($urandom_range(1, 0));
      exp = ref_add(x, y, ci);
      drive_start(x, y, ci);
      wait_done(N + 4, cyc);
      checks++; if (cyc != int'(N)) begin failures++; $display("FAIL rand_latency t=%0d got=%0d exp=%0d", t, cyc, N); end
      checks++;
      if ({c_out, sum} !== exp) begin
        failures++; $display("FAIL rand_result t=%0d got=%b_%h exp=%b_%h", t, c_out, sum, exp[W], exp[W-1:0]);
      end
      repeat (int'($urandom_range(3, 1))) @(posedge clk);
    end
  endtask

  task automatic test_ignored_input();
    int cyc;
    int extra;
    logic [W-1:0] x, y;
    logic [W:0] exp;
    x = rnd64(); y = rnd64();
    exp = ref_add(x, y, 1'b1);
    drive_start(x, y, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = rnd64(); b = rnd64(); c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = rnd64(); b = rnd64();
    wait_done(N + 4, cyc);
    checks++; if (cyc != int'(N) - 5) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", cyc, N - 5); end
    checks++;
    if ({c_out, sum} !== exp) begin
      failures++; $display("FAIL ignore_result got=%b_%h exp=%b_%h", c_out, sum, exp[W], exp[W-1:0]);
    end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL ignore_extra_done got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int extra;
    logic [W-1:0] x, y;
    logic [W:0] exp;
    drive_start(64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_1111_1111_1111, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || c_out !== 1'b0) begin
      failures++; $display("FAIL midrst_clear busy=%b done=%b sum=%h cout=%b exp all 0", busy, done, sum, c_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", extra); end
    x = rnd64(); y = rnd64();
    exp = ref_add(x, y, 1'b0);
    drive_start(x, y, 1'b0);
    wait_done(N + 4, cyc);
    checks++; if (cyc != int'(N)) begin failures++; $display("FAIL midrst_latency got=%0d exp=%0d", cyc, N); end
    checks++;
    if ({c_out, sum} !== exp) begin
      failures++; $display("FAIL midrst_result got=%b_%h exp=%b_%h", c_out, sum, exp[W], exp[W-1:0]);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] opa [40];
    logic [W-1:0] opb [40];
    logic         opc [40];
    logic [W:0]   exp;
    logic         exp_done;
    int           ndone;
    int           acc;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c < 40) begin
        opa[c] = rnd64(); opb[c] = rnd64(); opc[c] = 1'($urandom_range(1, 0));
        a = opa[c]; b = opb[c]; c_in = opc[c]; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      // Accepts at edges 0, 18, 36; each result appears N edges later.
      exp_done = (c >= 16) && ((c - 16) % 18 == 0) && ((c - 16) / 18 <= 2);
      checks++;
      if (done !== exp_done) begin
        failures++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", c, done, exp_done);
      end
      if (exp_done) begin
        ndone++;
        acc = c - 16;
        exp = ref_add(opa[acc], opb[acc], opc[acc]);
        checks++;
        if ({c_out, sum} !== exp) begin
          failures++; $display("FAIL b2b_result cyc=%0d got=%b_%h exp=%b_%h", c, c_out, sum, exp[W], exp[W-1:0]);
        end
      end
    end
    checks++; if (ndone != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", ndone); end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int cyc;
    logic [W-1:0] xs [4];
    logic [W-1:0] ys [4];
    logic [W:0] exp;
    xs[0] = 64'd5; ys[0] = 64'd7;
    xs[1] = 64'd7; ys[1] = 64'd5;
    xs[2] = rnd64(); ys[2] = rnd64();
    xs[3] = rnd64(); ys[3] = xs[3];
    sub = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp = ref_sub(xs[t], ys[t]);
      drive_start(xs[t], ys[t], 1'($urandom_range(1, 0)));
      wait_done(N + 4, cyc);
      checks++;
      if (cyc != int'(N) || {c_out, sum} !== exp) begin
        failures++; $display("FAIL sub_result t=%0d cyc=%0d got=%b_%h exp=%b_%h", t, cyc, c_out, sum, exp[W], exp[W-1:0]);
      end
      repeat (2) @(posedge clk);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_random();
    test_ignored_input();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
